// File: rtl/tdm_demux4.sv
// Receive-side demultiplexer for a bit-interleaved four-channel serial stream.
// Tracks slot/bit position, assembles one WIDTH-bit word per channel and reports framing loss.
module tdm_demux4 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             din,
   input  logic             din_vld,
   input  logic             frame_start,
   output logic [WIDTH-1:0] ch0,
   output logic [WIDTH-1:0] ch1,
   output logic [WIDTH-1:0] ch2,
   output logic [WIDTH-1:0] ch3,
   output logic             word_vld,
   output logic             frame_err,
   output logic             locked
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_slot;
   logic [1:0]       w_slot_nxt;
   logic [BW-1:0]    r_bit;
   logic [BW-1:0]    w_bit_nxt;
   logic [WIDTH-1:0] r_sr [4];
   logic [WIDTH-1:0] r_ch [4];
   logic             r_word_vld;
   logic             r_frame_err;
   logic             r_locked;
   logic             w_start;
   logic             w_shift;
   logic             w_load;
   logic             w_err;

   always_comb begin
      w_state_nxt = r_state;
      w_slot_nxt  = r_slot;
      w_bit_nxt   = r_bit;
      w_start     = 1'b0;
      w_shift     = 1'b0;
      w_load      = 1'b0;
      w_err       = 1'b0;
      if (din_vld) begin
         case (r_state)
            S_IDLE: begin
               if (frame_start) begin
                  w_start     = 1'b1;
                  w_state_nxt = S_RUN;
               end
            end
            S_RUN: begin
               if (r_slot == 2'd0 && r_bit == '0) begin
                  // A word boundary must carry frame_start, otherwise sync is gone.
                  if (frame_start) begin
                     w_start = 1'b1;
                  end else begin
                     w_err       = 1'b1;
                     w_state_nxt = S_IDLE;
                  end
               end else if (frame_start) begin
                  w_err   = 1'b1;
                  w_start = 1'b1;
               end else begin
                  w_shift    = 1'b1;
                  w_slot_nxt = r_slot + 2'd1;
                  if (r_slot == 2'd3) begin
                     if (r_bit == LAST_BIT) begin
                        w_load    = 1'b1;
                        w_bit_nxt = '0;
                     end else begin
                        w_bit_nxt = r_bit + BW'(1);
                     end
                  end
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
      if (w_start) begin
         w_slot_nxt = 2'd1;
         w_bit_nxt  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_slot      <= 2'd0;
         r_bit       <= '0;
         r_word_vld  <= 1'b0;
         r_frame_err <= 1'b0;
         r_locked    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_sr[i] <= '0;
            r_ch[i] <= '0;
         end
      end else begin
         r_state     <= w_state_nxt;
         r_slot      <= w_slot_nxt;
         r_bit       <= w_bit_nxt;
         r_word_vld  <= w_load;
         r_frame_err <= w_err;
         r_locked    <= (w_state_nxt == S_RUN);
         // Bits are written in place, so stale bits of an aborted word are always overwritten.
         if (w_start) begin
            r_sr[0][0] <= din;
         end else if (w_shift) begin
            r_sr[r_slot][r_bit] <= din;
         end
         if (w_load) begin
            r_ch[0] <= r_sr[0];
            r_ch[1] <= r_sr[1];
            r_ch[2] <= r_sr[2];
            r_ch[3] <= {din, r_sr[3][WIDTH-2:0]};
         end
      end
   end

   assign ch0       = r_ch[0];
   assign ch1       = r_ch[1];
   assign ch2       = r_ch[2];
   assign ch3       = r_ch[3];
   assign word_vld  = r_word_vld;
   assign frame_err = r_frame_err;
   assign locked    = r_locked;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4 (WIDTH=8): table of word records plus hand-written framing/reset sequences,
// with a scoreboard queue checked whenever word_vld fires.
module tb_tdm_demux4;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         din;
   logic         din_vld;
   logic         frame_start;
   logic [W-1:0] ch0;
   logic [W-1:0] ch1;
   logic [W-1:0] ch2;
   logic [W-1:0] ch3;
   logic         word_vld;
   logic         frame_err;
   logic         locked;

   tdm_demux4 #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_vld    (din_vld),
      .frame_start(frame_start),
      .ch0        (ch0),
      .ch1        (ch1),
      .ch2        (ch2),
      .ch3        (ch3),
      .word_vld   (word_vld),
      .frame_err  (frame_err),
      .locked     (locked)
   );

   typedef struct {
      logic [4*W-1:0] w;
      int             cyc;
   } sb_t;

   typedef struct {
      logic [4*W-1:0] w;
      int             gap;
      bit             fs;
      int             idle;
      bit             exp_word;
      int             exp_err;
      bit             exp_lock;
   } vec_t;

   sb_t            sb[$];
   vec_t           tbl[5];
   int             total = 0;
   int             bad = 0;
   int             cyc = 0;
   int             wvld_cnt = 0;
   int             err_cnt = 0;
   int             last_err_cyc = -1;
   bit             prev_wvld = 0;
   bit             prev_err = 0;
   logic [4*W-1:0] last_w = '0;
   int             err_base;
   int             wvld_base;
   int             first_cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (word_vld) begin
            wvld_cnt <= wvld_cnt + 1;
            check("wvld_b2b", 32'(prev_wvld), 0);
            check("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               check("word", {ch3, ch2, ch1, ch0}, sb[0].w);
               check("wvld_cyc", cyc, sb[0].cyc);
               void'(sb.pop_front());
            end
         end
         if (frame_err) begin
            err_cnt <= err_cnt + 1;
            check("ferr_width", 32'(prev_err), 0);
            last_err_cyc <= cyc;
         end
         prev_wvld <= word_vld;
         prev_err  <= frame_err;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         din_vld     = 1'b0;
         frame_start = 1'b0;
      end
   endtask

   // Drives the first nbeats of a bit-interleaved word; a full word that is expected is scoreboarded.
   task automatic send_word(input logic [4*W-1:0] w, input int nbeats, input int gap,
                            input bit fs, input bit push, output int fcyc);
      fcyc = 0;
      for (int i = 0; i < nbeats; i++) begin
         int b;
         int k;
         b = i / 4;
         k = i % 4;
         @(negedge clk);
         din         = w[k*W + b];
         din_vld     = 1'b1;
         frame_start = fs && (i == 0);
         if (i == 0) fcyc = cyc;
         if (i == 4*W - 1 && push) begin
            sb.push_back('{w: w, cyc: cyc + 1});
            last_w = w;
         end
         if (i != nbeats - 1 && gap > 0) begin
            repeat ($urandom_range(0, gap)) begin
               @(negedge clk);
               din_vld     = 1'b0;
               frame_start = 1'b0;
               din         = 1'($urandom);
            end
         end
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      din         = 1'b0;
      din_vld     = 1'b0;
      frame_start = 1'b0;

      tbl[0] = '{w: 32'h01FF3CA5, gap: 0, fs: 1, idle: 0, exp_word: 1, exp_err: 0, exp_lock: 1};
      tbl[1] = '{w: 32'h8000C35A, gap: 0, fs: 1, idle: 2, exp_word: 1, exp_err: 0, exp_lock: 1};
      tbl[2] = '{w: 32'h01FF3CA5, gap: 3, fs: 1, idle: 2, exp_word: 1, exp_err: 0, exp_lock: 1};
      tbl[3] = '{w: 32'h78563412, gap: 0, fs: 0, idle: 2, exp_word: 0, exp_err: 1, exp_lock: 0};
      tbl[4] = '{w: 32'h8000C35A, gap: 1, fs: 1, idle: 3, exp_word: 1, exp_err: 0, exp_lock: 1};

      #3;
      check("rst_ch", {ch3, ch2, ch1, ch0}, 0);
      check("rst_wvld", 32'(word_vld), 0);
      check("rst_ferr", 32'(frame_err), 0);
      check("rst_lock", 32'(locked), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      err_base = err_cnt;

      for (int r = 0; r < 5; r++) begin
         send_word(tbl[r].w, 4*W, tbl[r].gap, tbl[r].fs, tbl[r].exp_word, first_cyc);
         if (tbl[r].idle > 0) begin
            idle(tbl[r].idle);
            check("row_err", err_cnt - err_base, tbl[r].exp_err);
            if (tbl[r].exp_err > 0) check("row_err_cyc", last_err_cyc, first_cyc + 1);
            check("row_lock", 32'(locked), 32'(tbl[r].exp_lock));
            check("row_hold", {ch3, ch2, ch1, ch0}, last_w);
            err_base = err_cnt;
         end
      end

      // Early frame_start on beat 13 restarts the word there.
      wvld_base = wvld_cnt;
      send_word(32'h13579BDF, 12, 0, 1, 0, first_cyc);
      send_word(32'hEFBEADDE, 4*W, 0, 1, 1, first_cyc);
      idle(2);
      check("early_err", err_cnt - err_base, 1);
      check("early_err_cyc", last_err_cyc, first_cyc + 1);
      check("early_lock", 32'(locked), 1);
      check("early_word", {ch3, ch2, ch1, ch0}, 32'hEFBEADDE);
      check("early_wvld_cnt", wvld_cnt - wvld_base, 1);
      err_base = err_cnt;

      // Asynchronous reset in the middle of beat 20.
      send_word(32'h2468ACE0, 19, 0, 1, 0, first_cyc);
      @(negedge clk);
      din         = 1'b1;
      din_vld     = 1'b1;
      frame_start = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_ch", {ch3, ch2, ch1, ch0}, 0);
      check("arst_wvld", 32'(word_vld), 0);
      check("arst_ferr", 32'(frame_err), 0);
      check("arst_lock", 32'(locked), 0);
      din_vld = 1'b0;
      last_w  = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Random beats in IDLE without frame_start.
      err_base  = err_cnt;
      wvld_base = wvld_cnt;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         din         = 1'($urandom);
         din_vld     = 1'b1;
         frame_start = 1'b0;
      end
      idle(2);
      check("noise_err", err_cnt - err_base, 0);
      check("noise_wvld", wvld_cnt - wvld_base, 0);
      check("noise_lock", 32'(locked), 0);
      check("noise_ch", {ch3, ch2, ch1, ch0}, 0);

      send_word(32'h44332211, 4*W, 2, 1, 1, first_cyc);
      idle(2);
      check("fresh_word", {ch3, ch2, ch1, ch0}, 32'h44332211);
      check("fresh_lock", 32'(locked), 1);
      check("fresh_err", err_cnt - err_base, 0);
      check("sb_drain", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
